// File: rtl/core_writeback.sv
// rtl/core_writeback.sv - M/W writeback stage with load formatting, forwarding and hazard detection
// Single result slot in M waits for a load response; W drives the register-file write port.
module core_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ex_valid,
    output logic        o_ex_ready,
    input  logic [4:0]  i_ex_rd,
    input  logic [31:0] i_ex_data,
    input  logic        i_ex_load,
    input  logic [2:0]  i_ex_funct3,
    input  logic [1:0]  i_ex_addr_lo,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_re1,
    input  logic        i_re2,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic        o_hazard,
    output logic        o_forward1,
    output logic [4:0]  o_faddr1,
    output logic [31:0] o_fdata1,
    output logic        o_forward2,
    output logic [4:0]  o_faddr2,
    output logic [31:0] o_fdata2,
    output logic        o_we,
    output logic [4:0]  o_waddr,
    output logic [31:0] o_wdata,
    output logic [63:0] o_instret,
    output logic        o_spurious
);

    logic        r_m_valid;
    logic [4:0]  r_m_rd;
    logic [31:0] r_m_data;
    logic        r_m_load;
    logic        r_m_ready;
    logic [2:0]  r_m_funct3;
    logic [1:0]  r_m_addr_lo;
    logic        r_w_valid;
    logic [4:0]  r_w_rd;
    logic [31:0] r_w_data;
    logic [63:0] r_instret;
    logic        r_spurious;

    logic        w_accept;
    logic        w_m_move;
    logic        w_resp_ok;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;
    logic        w_hz_m;
    logic        w_hz_ex;

    assign o_ex_ready = !r_m_valid || r_m_ready;
    assign w_accept   = i_ex_valid && o_ex_ready;
    assign w_m_move   = r_m_valid && r_m_ready;
    assign w_resp_ok  = i_mem_rvalid && r_m_valid && r_m_load && !r_m_ready;

    // Unlisted funct3 encodings fall through to a full word.
    always_comb begin
        w_byte = i_mem_rdata[{r_m_addr_lo, 3'b000} +: 8];
        w_half = i_mem_rdata[{r_m_addr_lo[1], 4'b0000} +: 16];
        case (r_m_funct3)
            3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
            3'b100:  w_fmt = {24'd0, w_byte};
            3'b101:  w_fmt = {16'd0, w_half};
            default: w_fmt = i_mem_rdata;
        endcase
    end

    assign w_hz_m  = r_m_valid && r_m_load && !r_m_ready && (r_m_rd != 5'd0) && !i_mem_rvalid &&
                     ((i_re1 && (i_raddr1 == r_m_rd)) || (i_re2 && (i_raddr2 == r_m_rd)));
    assign w_hz_ex = w_accept && i_ex_load && (i_ex_rd != 5'd0) &&
                     ((i_re1 && (i_raddr1 == i_ex_rd)) || (i_re2 && (i_raddr2 == i_ex_rd)));
    assign o_hazard = w_hz_m || w_hz_ex;

    assign o_forward1 = w_m_move && (r_m_rd != 5'd0);
    assign o_faddr1   = r_m_rd;
    assign o_fdata1   = r_m_data;
    assign o_forward2 = w_resp_ok && (r_m_rd != 5'd0);
    assign o_faddr2   = r_m_rd;
    assign o_fdata2   = w_fmt;
    assign o_we       = r_w_valid && (r_w_rd != 5'd0);
    assign o_waddr    = r_w_rd;
    assign o_wdata    = r_w_data;
    assign o_instret  = r_instret;
    assign o_spurious = r_spurious;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid  <= 1'b0;
            r_m_ready  <= 1'b0;
            r_w_valid  <= 1'b0;
            r_instret  <= 64'd0;
            r_spurious <= 1'b0;
        end else begin
            r_spurious <= i_mem_rvalid && !w_resp_ok;
            r_instret  <= r_instret + {63'd0, r_w_valid};
            r_w_valid  <= w_m_move;
            if (w_m_move) begin
                r_w_rd   <= r_m_rd;
                r_w_data <= r_m_data;
            end
            // Accept and M-to-W move share a cycle so ALU results stream one per clock.
            if (w_accept) begin
                r_m_valid   <= 1'b1;
                r_m_rd      <= i_ex_rd;
                r_m_data    <= i_ex_data;
                r_m_load    <= i_ex_load;
                r_m_ready   <= !i_ex_load;
                r_m_funct3  <= i_ex_funct3;
                r_m_addr_lo <= i_ex_addr_lo;
            end else if (w_m_move) begin
                r_m_valid <= 1'b0;
            end else if (w_resp_ok) begin
                r_m_data  <= w_fmt;
                r_m_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_writeback.sv
// tb/tb_core_writeback.sv - directed scenarios plus randomized run against a transaction-level model
module tb_core_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ex_valid;
    logic        o_ex_ready;
    logic [4:0]  i_ex_rd;
    logic [31:0] i_ex_data;
    logic        i_ex_load;
    logic [2:0]  i_ex_funct3;
    logic [1:0]  i_ex_addr_lo;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        i_re1, i_re2;
    logic [4:0]  i_raddr1, i_raddr2;
    logic        o_hazard;
    logic        o_forward1;
    logic [4:0]  o_faddr1;
    logic [31:0] o_fdata1;
    logic        o_forward2;
    logic [4:0]  o_faddr2;
    logic [31:0] o_fdata2;
    logic        o_we;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic [63:0] o_instret;
    logic        o_spurious;

    int total = 0;
    int bad   = 0;

    core_writeback dut (
        .clk(clk), .rst(rst),
        .i_ex_valid(i_ex_valid), .o_ex_ready(o_ex_ready), .i_ex_rd(i_ex_rd), .i_ex_data(i_ex_data),
        .i_ex_load(i_ex_load), .i_ex_funct3(i_ex_funct3), .i_ex_addr_lo(i_ex_addr_lo),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .i_re1(i_re1), .i_re2(i_re2), .i_raddr1(i_raddr1), .i_raddr2(i_raddr2),
        .o_hazard(o_hazard),
        .o_forward1(o_forward1), .o_faddr1(o_faddr1), .o_fdata1(o_fdata1),
        .o_forward2(o_forward2), .o_faddr2(o_faddr2), .o_fdata2(o_fdata2),
        .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
        .o_instret(o_instret), .o_spurious(o_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load result from the architectural rules: pick lane by shifting, then extend.
    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    logic [36:0]     expw [int];
    bit              outst;
    logic [4:0]      o_rd;
    logic [2:0]      o_f3;
    logic [1:0]      o_a;
    longint unsigned nret;
    bit              spur_exp;
    bit              acc;
    bit              hz;

    initial begin
        rst = 1'b1; i_ex_valid = 0; i_ex_rd = 0; i_ex_data = 0; i_ex_load = 0;
        i_ex_funct3 = 0; i_ex_addr_lo = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
        i_re1 = 0; i_re2 = 0; i_raddr1 = 0; i_raddr2 = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_ready", o_ex_ready, 1); chk("rst_we", o_we, 0);
        chk("rst_fwd1", o_forward1, 0); chk("rst_fwd2", o_forward2, 0);
        chk("rst_hazard", o_hazard, 0); chk("rst_instret", o_instret, 0);
        chk("rst_spurious", o_spurious, 0);
        tick();

        // ALU x5 = 0x1234
        i_ex_valid = 1; i_ex_rd = 5; i_ex_data = 32'h1234; i_ex_load = 0; #1;
        chk("alu_ready", o_ex_ready, 1); tick();
        i_ex_valid = 0; #1;
        chk("alu_fwd1", o_forward1, 1); chk("alu_faddr1", o_faddr1, 5);
        chk("alu_fdata1", o_fdata1, 32'h1234); chk("alu_we_early", o_we, 0); tick();
        #1;
        chk("alu_we", o_we, 1); chk("alu_waddr", o_waddr, 5); chk("alu_wdata", o_wdata, 32'h1234); tick();
        #1; chk("alu_instret", o_instret, 1);

        // LB x7 from byte 3, response in cycle 3
        i_ex_valid = 1; i_ex_rd = 7; i_ex_load = 1; i_ex_funct3 = 3'd0; i_ex_addr_lo = 2'd3; #1; tick();
        i_ex_valid = 0; #1; chk("lb_ready_c1", o_ex_ready, 0); tick();
        #1; chk("lb_ready_c2", o_ex_ready, 0); tick();
        i_mem_rvalid = 1; i_mem_rdata = 32'h80FF_0000; #1;
        chk("lb_ready_c3", o_ex_ready, 0); chk("lb_fwd2", o_forward2, 1);
        chk("lb_faddr2", o_faddr2, 7); chk("lb_fdata2", o_fdata2, 32'hFFFF_FF80); tick();
        i_mem_rvalid = 0; #1;
        chk("lb_we_c4", o_we, 0); chk("lb_fdata1", o_fdata1, 32'hFFFF_FF80); tick();
        #1; chk("lb_we", o_we, 1); chk("lb_waddr", o_waddr, 7); chk("lb_wdata", o_wdata, 32'hFFFF_FF80); tick();
        #1; chk("lb_instret", o_instret, 2);

        // Load-use hazard on x9 via rs2
        i_re2 = 1; i_raddr2 = 9;
        i_ex_valid = 1; i_ex_rd = 9; i_ex_load = 1; i_ex_funct3 = 3'd2; i_ex_addr_lo = 0; #1;
        chk("hz_accept", o_hazard, 1); tick();
        i_ex_valid = 0; #1; chk("hz_c1", o_hazard, 1); tick();
        #1; chk("hz_c2", o_hazard, 1); tick();
        i_mem_rvalid = 1; i_mem_rdata = 32'hCAFE_BABE; #1;
        chk("hz_resp", o_hazard, 0); chk("hz_fwd2", o_forward2, 1); chk("hz_fdata2", o_fdata2, 32'hCAFE_BABE); tick();
        i_mem_rvalid = 0; i_re2 = 0; tick(); tick();

        // ALU write to x0
        i_ex_valid = 1; i_ex_rd = 0; i_ex_data = 32'hDEAD; i_ex_load = 0; #1; tick();
        i_ex_valid = 0; #1; chk("x0_fwd1", o_forward1, 0); tick();
        #1; chk("x0_we", o_we, 0); tick();
        #1; chk("x0_instret", o_instret, 4);

        // Spurious response with M empty
        i_mem_rvalid = 1; i_mem_rdata = 32'h5555_AAAA; #1; chk("sp_fwd2", o_forward2, 0); tick();
        i_mem_rvalid = 0; #1; chk("sp_pulse", o_spurious, 1); chk("sp_ready", o_ex_ready, 1); tick();
        #1; chk("sp_clear", o_spurious, 0); chk("sp_instret", o_instret, 4); chk("sp_we", o_we, 0);

        // Reset during pending LHU x3; response in reset cycle is ignored
        i_re1 = 1; i_raddr1 = 3;
        i_ex_valid = 1; i_ex_rd = 3; i_ex_load = 1; i_ex_funct3 = 3'd5; i_ex_addr_lo = 2; #1;
        chk("rl_hz", o_hazard, 1); tick();
        i_ex_valid = 0; #1; chk("rl_ready_pend", o_ex_ready, 0);
        rst = 1; i_mem_rvalid = 1; i_mem_rdata = 32'h1234_5678; tick();
        rst = 0; i_mem_rvalid = 0; #1;
        chk("rl_ready", o_ex_ready, 1); chk("rl_fwd1", o_forward1, 0); chk("rl_fwd2", o_forward2, 0);
        chk("rl_we", o_we, 0); chk("rl_hazard", o_hazard, 0); chk("rl_spurious", o_spurious, 0);
        chk("rl_instret", o_instret, 0);
        i_mem_rvalid = 1; tick();
        i_mem_rvalid = 0; i_re1 = 0; #1; chk("rl_late_sp", o_spurious, 1); chk("rl_late_we", o_we, 0); tick();
        #1; chk("rl_late_clr", o_spurious, 0); chk("rl_late_we2", o_we, 0);

        // Randomized run against a write-schedule model
        rst = 1; tick(); rst = 0;
        outst = 0; nret = 0; spur_exp = 0;
        for (int c = 0; c < 800; c++) begin
            if (!outst) begin
                i_ex_valid   = ($urandom % 10) < 7;
                i_ex_rd      = 5'($urandom % 8);
                i_ex_data    = $urandom;
                i_ex_load    = ($urandom % 3) == 0;
                i_ex_funct3  = 3'($urandom % 8);
                i_ex_addr_lo = 2'($urandom % 4);
            end
            i_mem_rvalid = outst ? (($urandom % 3) == 0) : (($urandom % 20) == 0);
            i_mem_rdata  = $urandom;
            i_re1 = $urandom % 2; i_re2 = $urandom % 2;
            i_raddr1 = 5'($urandom % 8); i_raddr2 = 5'($urandom % 8);
            #1;
            acc = i_ex_valid && !outst;
            hz = (outst && o_rd != 0 && !i_mem_rvalid &&
                  ((i_re1 && i_raddr1 == o_rd) || (i_re2 && i_raddr2 == o_rd))) ||
                 (acc && i_ex_load && i_ex_rd != 0 &&
                  ((i_re1 && i_raddr1 == i_ex_rd) || (i_re2 && i_raddr2 == i_ex_rd)));
            chk("r_ready", o_ex_ready, !outst);
            chk("r_hazard", o_hazard, hz);
            chk("r_spurious", o_spurious, spur_exp);
            chk("r_instret", o_instret, nret);
            if (expw.exists(c + 1) && expw[c + 1][36:32] != 0) begin
                chk("r_fwd1", o_forward1, 1);
                chk("r_fwd1_word", {o_faddr1, o_fdata1}, expw[c + 1]);
            end else begin
                chk("r_fwd1", o_forward1, 0);
            end
            if (i_mem_rvalid && outst && o_rd != 0) begin
                chk("r_fwd2", o_forward2, 1);
                chk("r_fwd2_word", {o_faddr2, o_fdata2}, {o_rd, fmt(o_f3, o_a, i_mem_rdata)});
            end else begin
                chk("r_fwd2", o_forward2, 0);
            end
            if (expw.exists(c) && expw[c][36:32] != 0) begin
                chk("r_we", o_we, 1);
                chk("r_we_word", {o_waddr, o_wdata}, expw[c]);
            end else begin
                chk("r_we", o_we, 0);
            end
            spur_exp = i_mem_rvalid && !outst;
            if (i_mem_rvalid && outst) begin
                expw[c + 2] = {o_rd, fmt(o_f3, o_a, i_mem_rdata)};
                outst = 0;
            end
            if (acc) begin
                if (i_ex_load) begin
                    outst = 1; o_rd = i_ex_rd; o_f3 = i_ex_funct3; o_a = i_ex_addr_lo;
                end else begin
                    expw[c + 2] = {i_ex_rd, i_ex_data};
                end
            end
            if (expw.exists(c)) nret++;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_writeback.md
CORE_WRITEBACK -- requirements
Module: core_writeback

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_ex_valid  in  1  EX result offered.
- o_ex_ready  out  1  EX result accepted this cycle when high with i_ex_valid.
- i_ex_rd  in  5  destination register.
- i_ex_data  in  32  ALU result; ignored for loads.
- i_ex_load  in  1  result is a load; data arrives later from memory.
- i_ex_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- i_ex_addr_lo  in  2  load byte address bits [1:0].
- i_mem_rvalid  in  1  load response valid, single-cycle pulse.
- i_mem_rdata  in  32  load response word.
- i_re1, i_re2  in  1 each  decode reads rs1/rs2.
- i_raddr1, i_raddr2  in  5 each  decode read addresses.
- o_hazard  out  1  load-use stall request to decode.
- o_forward1, o_faddr1, o_fdata1  out  1/5/32  M-stage forward port.
- o_forward2, o_faddr2, o_fdata2  out  1/5/32  load-response bypass port.
- o_we, o_waddr, o_wdata  out  1/5/32  register-file write port.
- o_instret  out  64  retired-result counter.
- o_spurious  out  1  registered pulse: response with no load pending.
REQ-002 SHALL use one clock; reset SHALL be synchronous and active-high, named rst.

Function
REQ-003 SHALL hold a two-stage pipe: M (valid, rd, data, load, ready, funct3, addr_lo) and W (valid, rd, data).
REQ-004 o_ex_ready SHALL be combinational: !m_valid || m_ready.
REQ-005 On accept, M SHALL capture the EX fields; ready=1 for non-load, ready=0 for load.
REQ-006 If m_valid && m_ready, M SHALL move to W that cycle; m_valid SHALL then equal the accept condition. Otherwise w_valid<=0.
REQ-007 Same-cycle accept and M-to-W move SHALL both occur, allowing back-to-back ALU results at one per cycle.
REQ-008 If i_mem_rvalid && m_valid && m_load && !m_ready, M data SHALL take the formatted word and ready<=1.
REQ-009 Load formatting SHALL work as follows:
- Byte = rdata[8*addr_lo +: 8]; half = rdata[16*addr_lo[1] +: 16].
- LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend.
- Funct3 011, 110 and 111 SHALL be treated as LW.
REQ-010 A response with no pending unready load SHALL be dropped and raise o_spurious for exactly the next cycle.
REQ-011 o_forward1 SHALL equal m_valid && m_ready && m_rd!=0, with o_faddr1=m_rd and o_fdata1=m_data.
REQ-012 o_forward2 SHALL equal the REQ-008 condition && m_rd!=0, with o_faddr2=m_rd and o_fdata2=formatted i_mem_rdata (combinational, zero added latency).
REQ-013 o_we SHALL equal w_valid && w_rd!=0, with o_waddr=w_rd and o_wdata=w_data. Writes to x0 SHALL never assert o_we.
REQ-014 o_hazard SHALL be asserted when all of the following hold:
- m_valid && m_load && !m_ready && m_rd!=0;
- !i_mem_rvalid;
- (i_re1 && i_raddr1==m_rd) || (i_re2 && i_raddr2==m_rd).
REQ-015 o_hazard SHALL also be asserted when an EX load with i_ex_rd!=0 is accepted and matches an enabled decode address under the same rule.
REQ-016 o_instret SHALL increment by 1 for every W-valid cycle, including rd=0, and SHALL wrap at 2^64.
REQ-017 Load latency from accept to o_we SHALL be (response cycle - accept cycle) + 2. ALU latency from accept to o_we SHALL be exactly 2 cycles.
REQ-018 Non-faulting order SHALL be preserved: results SHALL reach W in accept order.
REQ-019 While a load waits, o_ex_ready SHALL be 0 and EX SHALL hold its fields unchanged.

Reset
REQ-020 With rst high at a clock edge, m_valid, w_valid, o_instret and o_spurious SHALL clear.
REQ-021 All forward, write and hazard outputs SHALL read 0 from the first cycle after reset. o_ex_ready SHALL read 1.
REQ-022 A load pending when reset asserts SHALL be discarded. A response arriving in the reset cycle SHALL be ignored and SHALL NOT pulse o_spurious.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- ALU x5=0x1234 accepted cycle 0 -> forward1 {x5, 0x1234} in cycle 1; o_we {x5, 0x1234} in cycle 2; o_instret=1.
- LB x7, addr_lo=3, response 0x80FF_0000 at cycle 3 -> forward2 {x7, 0xFFFF_FF80} in cycle 3; o_we in cycle 5; o_ex_ready=0 in cycles 1-3.
- Load x9 pending, decode i_re2 with raddr2=9 -> o_hazard=1 until the response cycle, then 0 with forward2 active.
- ALU result to x0 with data 0xDEAD -> o_we and o_forward1 stay 0; o_instret increments.
- i_mem_rvalid with M empty -> o_spurious=1 for one cycle; no state change.
- rst during a pending LHU -> o_ex_ready=1 and all forwards and o_we at 0 the next cycle; a later response pulses o_spurious.
